// File: rtl/gated_mux_pipe.sv
// rtl/gated_mux_pipe.sv - per-channel gated 2:1 mux with delayed gate/valid and saturating hit counters
// Gate and valid travel through DEPTH-stage delay lines; mux data is used undelayed.

module gated_mux_pipe #(
   parameter int W     = 1,
   parameter int CH    = 1,
   parameter int DEPTH = 1,
   parameter int CNT_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  mode,
   input  logic [CH-1:0]         sel,
   input  logic [CH*W-1:0]       a,
   input  logic [CH*W-1:0]       b,
   input  logic [CH-1:0]         gate,
   input  logic                  clr,
   output logic [CH*W-1:0]       out,
   output logic                  out_valid,
   output logic [CH*CNT_W-1:0]   hit_cnt
);

   logic [CH-1:0]    gate_sr [DEPTH];
   logic [DEPTH-1:0] valid_sr;
   logic [CH-1:0]    gate_d;

   // Both delay lines shift every edge; there is no stall path.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) gate_sr[i] <= '0;
         valid_sr <= '0;
      end else begin
         gate_sr[0]  <= gate;
         valid_sr[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            gate_sr[i]  <= gate_sr[i-1];
            valid_sr[i] <= valid_sr[i-1];
         end
      end
   end

   assign gate_d    = gate_sr[DEPTH-1];
   assign out_valid = valid_sr[DEPTH-1];

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [W-1:0]     m;
      logic [W-1:0]     o;
      logic [CNT_W-1:0] cnt;
      logic             hit;

      assign m = sel[c] ? a[c*W +: W] : b[c*W +: W];
      assign o = {W{gate_d[c]}} & (mode ? m : ~m);
      assign out[c*W +: W] = o;
      assign hit = out_valid && (o != '0);

      // clr wins over a simultaneous hit; the count sticks at all-ones.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt <= '0;
         end else if (clr) begin
            cnt <= '0;
         end else if (hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      assign hit_cnt[c*CNT_W +: CNT_W] = cnt;
   end

endmodule
